// File: rtl/multicycle_alu.sv
// Multi-cycle EX-stage ALU: 17 single-cycle integer ops with registered result,
// plus iterative signed/unsigned multiply and divide into HI/LO.
module multicycle_alu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             zero,
   output logic             sml,
   output logic             overflow,
   output logic             div_by_zero
);

   localparam logic [1:0] S_IDLE = 2'd0, S_ITER = 2'd1, S_FIX = 2'd2, S_RES = 2'd3;

   localparam logic [4:0] OP_ADD  = 5'h00, OP_SUB  = 5'h01, OP_SLT  = 5'h02, OP_AND  = 5'h03,
                          OP_NOR  = 5'h04, OP_OR   = 5'h05, OP_XOR  = 5'h06, OP_SLL  = 5'h07,
                          OP_SRL  = 5'h08, OP_SLTU = 5'h09, OP_SLLV = 5'h0C, OP_SRA  = 5'h0D,
                          OP_SRAV = 5'h0E, OP_SRLV = 5'h0F, OP_LUI  = 5'h10, OP_MULT = 5'h11,
                          OP_MULTU = 5'h12, OP_DIV = 5'h13, OP_DIVU = 5'h14, OP_MFHI = 5'h15,
                          OP_MFLO = 5'h16;

   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [SHW:0]     CNT_INIT = (SHW+1)'(WIDTH);
   localparam logic [SHW:0]     CNT_ONE  = (SHW+1)'(1);

   logic [1:0]       state;
   logic [SHW:0]     count;
   logic             is_div, sign_q, neg_q, neg_r;
   logic [WIDTH-1:0] a_q, b_q, dvsr, acc_lo;
   logic [WIDTH:0]   acc_hi;

   assign ready = (state == S_IDLE);
   assign busy  = ~ready;
   assign done  = (state == S_RES);

   // single-cycle datapath, evaluated on the live inputs at accept
   logic [WIDTH-1:0] sc_res, sum, dif;
   logic             sc_ovf;
   logic [SHW-1:0]   sh;

   assign sh  = a[SHW-1:0];
   assign sum = a + b;
   assign dif = a - b;

   always_comb begin
      sc_res = '0;
      sc_ovf = 1'b0;
      case (op)
         OP_ADD: begin
            sc_res = sum;
            sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            sc_res = dif;
            sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SLT:           sc_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         OP_AND:           sc_res = a & b;
         OP_NOR:           sc_res = ~(a | b);
         OP_OR:            sc_res = a | b;
         OP_XOR:           sc_res = a ^ b;
         OP_SLL, OP_SLLV:  sc_res = b << sh;
         OP_SRL, OP_SRLV:  sc_res = b >> sh;
         OP_SLTU:          sc_res = {{(WIDTH-1){1'b0}}, a < b};
         OP_SRA, OP_SRAV:  sc_res = $signed(b) >>> sh;
         OP_LUI:           sc_res = b << (WIDTH/2);
         OP_MFHI:          sc_res = hi;
         OP_MFLO:          sc_res = lo;
         default:          sc_res = '0;
      endcase
   end

   logic             is_multi, sign_in;
   logic [WIDTH-1:0] mag_a, mag_b;

   assign is_multi = (op >= OP_MULT) && (op <= OP_DIVU);
   assign sign_in  = (op == OP_MULT) || (op == OP_DIV);
   assign mag_a    = (sign_in && a[WIDTH-1]) ? -a : a;
   assign mag_b    = (sign_in && b[WIDTH-1]) ? -b : b;

   // one iteration: shift-add for multiply, restoring subtract for divide
   logic [WIDTH:0]   step_sum, rem_sh, rem_diff, nxt_hi;
   logic [WIDTH-1:0] nxt_lo;

   always_comb begin
      step_sum = acc_hi + (acc_lo[0] ? {1'b0, dvsr} : '0);
      rem_sh   = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
      rem_diff = rem_sh - {1'b0, dvsr};
      if (!is_div) begin
         nxt_hi = {1'b0, step_sum[WIDTH:1]};
         nxt_lo = {step_sum[0], acc_lo[WIDTH-1:1]};
      end else if (!rem_diff[WIDTH]) begin
         nxt_hi = rem_diff;
         nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
         nxt_hi = rem_sh;
         nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
   end

   // sign correction and divide special cases
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;
   logic               fix_ovf, fix_dbz;

   always_comb begin
      prod    = {acc_hi[WIDTH-1:0], acc_lo};
      quo     = neg_q ? -acc_lo : acc_lo;
      rem     = neg_r ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
      fix_ovf = 1'b0;
      fix_dbz = 1'b0;
      if (neg_q) prod = -prod;
      if (!is_div) begin
         fix_hi = prod[2*WIDTH-1:WIDTH];
         fix_lo = prod[WIDTH-1:0];
      end else if (b_q == '0) begin
         fix_hi  = a_q;
         fix_lo  = '1;
         fix_dbz = 1'b1;
      end else begin
         fix_hi  = rem;
         fix_lo  = quo;
         fix_ovf = sign_q && (a_q == MOST_NEG) && (b_q == '1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         count       <= '0;
         is_div      <= 1'b0;
         sign_q      <= 1'b0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         dvsr        <= '0;
         acc_lo      <= '0;
         acc_hi      <= '0;
         out         <= '0;
         hi          <= '0;
         lo          <= '0;
         zero        <= 1'b0;
         sml         <= 1'b0;
         overflow    <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               a_q <= a;
               b_q <= b;
               if (is_multi) begin
                  state  <= S_ITER;
                  count  <= CNT_INIT;
                  is_div <= (op == OP_DIV) || (op == OP_DIVU);
                  sign_q <= sign_in;
                  neg_q  <= sign_in && (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_r  <= sign_in && a[WIDTH-1];
                  acc_hi <= '0;
                  if ((op == OP_DIV) || (op == OP_DIVU)) begin
                     acc_lo <= mag_a;
                     dvsr   <= mag_b;
                  end else begin
                     acc_lo <= mag_b;
                     dvsr   <= mag_a;
                  end
               end else begin
                  state       <= S_RES;
                  out         <= sc_res;
                  zero        <= (sc_res == '0);
                  sml         <= (a < b);
                  overflow    <= sc_ovf;
                  div_by_zero <= 1'b0;
               end
            end
            S_ITER: begin
               acc_hi <= nxt_hi;
               acc_lo <= nxt_lo;
               count  <= count - CNT_ONE;
               if (count == CNT_ONE) state <= S_FIX;
            end
            S_FIX: begin
               hi          <= fix_hi;
               lo          <= fix_lo;
               out         <= fix_lo;
               zero        <= (fix_lo == '0);
               sml         <= (a_q < b_q);
               overflow    <= fix_ovf;
               div_by_zero <= fix_dbz;
               state       <= S_RES;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_alu.sv
// Randomized self-checking bench for multicycle_alu against an arithmetic reference model.
module tb_multicycle_alu;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [4:0]  op;
   logic [31:0] a, b;
   logic        ready, busy, done, zero, sml, overflow, div_by_zero;
   logic [31:0] out, hi, lo;

   int checks = 0;
   int errors = 0;
   logic [31:0] m_hi = '0, m_lo = '0;

   localparam longint MAXI = 64'sd2147483647;
   localparam longint MINI = -64'sd2147483648;

   multicycle_alu #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .ready(ready), .busy(busy), .done(done), .out(out), .hi(hi), .lo(lo),
      .zero(zero), .sml(sml), .overflow(overflow), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   // reference: expected out and flags {zero,sml,overflow,div_by_zero}; tracks HI/LO
   task automatic model_op(input logic [4:0] mop, input logic [31:0] ma, mb,
                           output logic [31:0] eo, output logic [3:0] ef);
      int ia, ib;
      longint sa, sb, s;
      logic [63:0] p;
      logic ev, ed;
      ia = ma; ib = mb; sa = ia; sb = ib;
      eo = '0; ev = 1'b0; ed = 1'b0;
      case (mop)
         5'h00: begin s = sa + sb; eo = ma + mb; ev = (s > MAXI) || (s < MINI); end
         5'h01: begin s = sa - sb; eo = ma - mb; ev = (s > MAXI) || (s < MINI); end
         5'h02: eo = {31'b0, ia < ib};
         5'h03: eo = ma & mb;
         5'h04: eo = ~(ma | mb);
         5'h05: eo = ma | mb;
         5'h06: eo = ma ^ mb;
         5'h07, 5'h0C: eo = mb << ma[4:0];
         5'h08, 5'h0F: eo = mb >> ma[4:0];
         5'h09: eo = {31'b0, ma < mb};
         5'h0D, 5'h0E: eo = ib >>> ma[4:0];
         5'h10: eo = mb << 16;
         5'h11: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; eo = m_lo; end
         5'h12: begin p = {32'b0, ma} * {32'b0, mb}; m_hi = p[63:32]; m_lo = p[31:0]; eo = m_lo; end
         5'h13, 5'h14: begin
            if (mb == 0) begin
               m_lo = '1; m_hi = ma; ed = 1'b1;
            end else if (mop == 5'h13 && ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) begin
               m_lo = 32'h8000_0000; m_hi = '0; ev = 1'b1;
            end else if (mop == 5'h13) begin
               m_lo = ia / ib; m_hi = ia % ib;
            end else begin
               m_lo = ma / mb; m_hi = ma % mb;
            end
            eo = m_lo;
         end
         5'h15: eo = m_hi;
         5'h16: eo = m_lo;
         default: eo = '0;
      endcase
      ef = {eo == 0, ma < mb, ev, ed};
   endtask

   function automatic logic [31:0] rnd_val();
      logic [31:0] edges [5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
      if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
      return $urandom;
   endfunction

   function automatic logic [4:0] rnd_single_op();
      int r;
      r = $urandom_range(0, 31);
      if (r >= 17 && r <= 20) r = r - 17;
      return 5'(r);
   endfunction

   // drives one request once ready, returns cycles from accept to the done cycle
   task automatic issue(input logic [4:0] iop, input logic [31:0] ia, ib, output int lat);
      int w;
      w = 0;
      @(negedge clk);
      while (!ready && w < 100) begin @(negedge clk); w++; end
      op = iop; a = ia; b = ib; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (!done && lat < 100) begin @(negedge clk); lat++; end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({ready, busy, done} !== 3'b100) begin
         errors++; $display("FAIL reset_ctrl: got rdy/busy/done=%b want 100", {ready, busy, done});
      end
      checks++;
      if ({out, hi, lo} !== 96'h0) begin
         errors++; $display("FAIL reset_regs: got out=%h hi=%h lo=%h want 0", out, hi, lo);
      end
      checks++;
      if ({zero, sml, overflow, div_by_zero} !== 4'b0) begin
         errors++; $display("FAIL reset_flags: got %b want 0000", {zero, sml, overflow, div_by_zero});
      end
      rst = 1'b0;
      m_hi = '0; m_lo = '0;
   endtask

   task automatic test_single_cycle();
      logic [4:0]  dop [4] = '{5'h00, 5'h0D, 5'h10, 5'h1F};
      logic [31:0] da  [4] = '{32'h7FFF_FFFF, 32'h24, 32'h0, 32'h5};
      logic [31:0] db  [4] = '{32'h1, 32'h8000_0000, 32'h1234, 32'h6};
      logic [31:0] eo;
      logic [3:0]  ef;
      logic [4:0]  cop;
      logic [31:0] ca, cb;
      int lat;
      for (int i = 0; i < 64; i++) begin
         if (i < 4) begin cop = dop[i]; ca = da[i]; cb = db[i]; end
         else begin cop = rnd_single_op(); ca = rnd_val(); cb = rnd_val(); end
         model_op(cop, ca, cb, eo, ef);
         issue(cop, ca, cb, lat);
         checks++;
         if (lat !== 1) begin errors++; $display("FAIL sc_latency op=%h: got %0d want 1", cop, lat); end
         checks++;
         if (out !== eo) begin
            errors++; $display("FAIL sc_out op=%h a=%h b=%h: got %h want %h", cop, ca, cb, out, eo);
         end
         checks++;
         if ({zero, sml, overflow, div_by_zero} !== ef) begin
            errors++; $display("FAIL sc_flags op=%h a=%h b=%h: got %b want %b", cop, ca, cb,
                               {zero, sml, overflow, div_by_zero}, ef);
         end
         checks++;
         if ({hi, lo} !== {m_hi, m_lo}) begin
            errors++; $display("FAIL sc_hilo_held op=%h: got %h_%h want %h_%h", cop, hi, lo, m_hi, m_lo);
         end
         @(negedge clk);
         checks++;
         if (ready !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL sc_ready_return op=%h: got rdy=%b done=%b want 1 0", cop, ready, done);
         end
      end
   endtask

   task automatic test_muldiv();
      logic [4:0]  dop [6] = '{5'h11, 5'h13, 5'h14, 5'h13, 5'h13, 5'h12};
      logic [31:0] da  [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h7, 32'h8000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
      logic [31:0] db  [6] = '{32'h7, 32'h2, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF};
      logic [31:0] eo;
      logic [3:0]  ef;
      logic [4:0]  cop;
      logic [31:0] ca, cb;
      int lat;
      for (int i = 0; i < 30; i++) begin
         if (i < 6) begin cop = dop[i]; ca = da[i]; cb = db[i]; end
         else begin
            cop = 5'(17 + $urandom_range(0, 3));
            ca = rnd_val();
            cb = ($urandom_range(0, 7) == 0) ? 32'h0 : rnd_val();
         end
         model_op(cop, ca, cb, eo, ef);
         issue(cop, ca, cb, lat);
         checks++;
         if (lat !== 34) begin errors++; $display("FAIL md_latency op=%h: got %0d want 34", cop, lat); end
         checks++;
         if ({hi, lo} !== {m_hi, m_lo}) begin
            errors++; $display("FAIL md_hilo op=%h a=%h b=%h: got %h_%h want %h_%h", cop, ca, cb,
                               hi, lo, m_hi, m_lo);
         end
         checks++;
         if (out !== eo) begin errors++; $display("FAIL md_out op=%h: got %h want %h", cop, out, eo); end
         checks++;
         if ({zero, sml, overflow, div_by_zero} !== ef) begin
            errors++; $display("FAIL md_flags op=%h a=%h b=%h: got %b want %b", cop, ca, cb,
                               {zero, sml, overflow, div_by_zero}, ef);
         end
         ca = rnd_val(); cb = rnd_val();
         model_op(5'h15, ca, cb, eo, ef);
         issue(5'h15, ca, cb, lat);
         checks++;
         if (out !== eo || lat !== 1) begin
            errors++; $display("FAIL mfhi: got %h lat %0d want %h lat 1", out, lat, eo);
         end
         model_op(5'h16, ca, cb, eo, ef);
         issue(5'h16, ca, cb, lat);
         checks++;
         if (out !== eo || {zero, sml, overflow, div_by_zero} !== ef) begin
            errors++; $display("FAIL mflo: got %h/%b want %h/%b", out, {zero, sml, overflow, div_by_zero}, eo, ef);
         end
      end
   endtask

   task automatic test_ignore_while_busy();
      logic [31:0] eo;
      logic [3:0]  ef;
      int cyc;
      model_op(5'h11, 32'h0001_2345, 32'hFFFF_0F0F, eo, ef);
      @(negedge clk);
      op = 5'h11; a = 32'h0001_2345; b = 32'hFFFF_0F0F; start = 1'b1;
      @(posedge clk);
      cyc = 0;
      do begin
         @(negedge clk); cyc++;
         op = 5'($urandom); a = $urandom; b = $urandom; start = (cyc < 30);
      end while (!done && cyc < 100);
      start = 1'b0;
      checks++;
      if (cyc !== 34) begin errors++; $display("FAIL busy_latency: got %0d want 34", cyc); end
      checks++;
      if (out !== eo || {hi, lo} !== {m_hi, m_lo}) begin
         errors++; $display("FAIL busy_ignore: got out=%h hi=%h lo=%h want %h %h %h", out, hi, lo, eo, m_hi, m_lo);
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0]  qop [8];
      logic [31:0] qa [8], qb [8];
      logic [31:0] eo;
      logic [3:0]  ef;
      int idx, cyc, last;
      for (int i = 0; i < 8; i++) begin qop[i] = rnd_single_op(); qa[i] = rnd_val(); qb[i] = rnd_val(); end
      @(negedge clk);
      op = qop[0]; a = qa[0]; b = qb[0]; start = 1'b1;
      idx = 0; cyc = 0; last = 0;
      while (idx < 8 && cyc < 100) begin
         @(negedge clk); cyc++;
         if (done) begin
            model_op(qop[idx], qa[idx], qb[idx], eo, ef);
            checks++;
            if (out !== eo) begin
               errors++; $display("FAIL b2b_out #%0d op=%h: got %h want %h", idx, qop[idx], out, eo);
            end
            if (idx > 0) begin
               checks++;
               if (cyc - last !== 2) begin errors++; $display("FAIL b2b_gap #%0d: got %0d want 2", idx, cyc - last); end
            end
            last = cyc;
            idx++;
            if (idx < 8) begin op = qop[idx]; a = qa[idx]; b = qb[idx]; end
            else start = 1'b0;
         end
      end
      start = 1'b0;
      checks++;
      if (idx !== 8) begin errors++; $display("FAIL b2b_count: got %0d want 8", idx); end
   endtask

   task automatic test_abort();
      logic [31:0] eo;
      logic [3:0]  ef;
      logic seen_done, seen_idle;
      int lat;
      model_op(5'h12, 32'd5, 32'd6, eo, ef);
      issue(5'h12, 32'd5, 32'd6, lat);
      checks++;
      if (lo !== 32'd30 || hi !== 32'd0) begin errors++; $display("FAIL abort_pre: got %h_%h want 0_1e", hi, lo); end
      @(negedge clk);
      op = 5'h12; a = 32'hDEAD_BEEF; b = 32'h1234_5678; start = 1'b1;
      @(posedge clk);
      seen_done = 1'b0; seen_idle = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         start = (k == 5);
         if (done) seen_done = 1'b1;
         if (!busy) seen_idle = 1'b1;
         if (k == 10) rst = 1'b1;
      end
      @(negedge clk);
      checks++;
      if (seen_done || seen_idle) begin
         errors++; $display("FAIL abort_busy: got done_seen=%b idle_seen=%b want 0 0", seen_done, seen_idle);
      end
      checks++;
      if (ready !== 1'b1 || done !== 1'b0 || {hi, lo, out} !== 96'h0) begin
         errors++; $display("FAIL abort_state: got rdy=%b done=%b hi=%h lo=%h out=%h want 1 0 0 0 0",
                            ready, done, hi, lo, out);
      end
      rst = 1'b0;
      m_hi = '0; m_lo = '0;
      seen_done = 1'b0;
      repeat (40) begin @(negedge clk); if (done) seen_done = 1'b1; end
      checks++;
      if (seen_done) begin errors++; $display("FAIL abort_no_done: got late done want none"); end
   endtask

   task automatic test_reset_start();
      logic seen;
      int lat;
      issue(5'h00, 32'd3, 32'd4, lat);
      @(negedge clk);
      rst = 1'b1; start = 1'b1; op = 5'h00; a = 32'd5; b = 32'd6;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      checks++;
      if (ready !== 1'b1 || out !== 32'h0) begin
         errors++; $display("FAIL rst_start: got rdy=%b out=%h want 1 0", ready, out);
      end
      seen = 1'b0;
      repeat (3) begin @(negedge clk); if (done) seen = 1'b1; end
      checks++;
      if (seen) begin errors++; $display("FAIL rst_start_dropped: got done want none"); end
      m_hi = '0; m_lo = '0;
   endtask

   initial begin
      test_reset();
      test_single_cycle();
      test_muldiv();
      test_ignore_while_busy();
      test_back_to_back();
      test_abort();
      test_reset_start();
      test_muldiv();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
